pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_pkg.sv | 24 ++
 rtl/pci_rr_picker.sv | 32 +++
 rtl/pci_arbiter.sv | 117 +++++++++++
 tb/tb_pci_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI arbiter definitions: arbiter state codes, parameter defaults and bus phase codes.
package pci_pkg;

  localparam int unsigned DefaultNReq       = 4;
  localparam int unsigned DefaultGntTimeout = 16;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StBusy    = 2'd2;
  localparam logic [1:0] StIllegal = 2'd3;

  typedef enum logic [1:0] {
    PhaseIdle,
    PhaseAddr,
    PhaseData,
    PhaseTurn
  } bus_phase_e;

  // FRAME# and IRDY# both deasserted means no transaction is in flight.
  function automatic logic bus_is_idle(input logic frame, input logic irdy);
    return frame & irdy;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: searches active-low requests starting after last_owner.
module pci_rr_picker
  import pci_pkg::*;
#(
  parameter int unsigned N_REQ = DefaultNReq,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  last_owner,
  output logic             valid,
  output logic [IdxW-1:0]  winner
);

  int unsigned idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = 32'(last_owner) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!valid && !req[idx[IdxW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grants with FRAME# timeout, preemption and no bus parking.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int unsigned N_REQ       = DefaultNReq,
  parameter int unsigned GNT_TIMEOUT = DefaultGntTimeout,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             frame,
  input  logic             irdy,
  output logic [N_REQ-1:0] gnt,
  output logic [IdxW-1:0]  owner,
  output logic [1:0]       state,
  output logic             bus_idle
);

  localparam logic [7:0]       TimeoutLast = 8'(GNT_TIMEOUT - 1);
  localparam logic [IdxW-1:0]  LastIdx     = IdxW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] GntNone     = '1;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  last_owner_q, last_owner_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             pick_valid;
  logic [IdxW-1:0]  pick_winner;
  logic [N_REQ-1:0] owner_mask;
  logic             owner_req;
  logic             others_req;

  pci_rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req       (req),
    .last_owner(last_owner_q),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  assign bus_idle   = bus_is_idle(frame, irdy);
  assign owner_mask = N_REQ'(1) << owner_q;
  assign owner_req  = ~req[owner_q];
  assign others_req = ~&(req | owner_mask);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        gnt_d = GntNone;
        if (bus_idle && pick_valid) begin
          gnt_d   = ~(N_REQ'(1) << pick_winner);
          owner_d = pick_winner;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 8'd1;
        // FRAME# wins over a timeout landing in the same cycle.
        if (!frame) begin
          state_d      = StBusy;
          last_owner_d = owner_q;
        end else if (!owner_req) begin
          gnt_d   = GntNone;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          // Stalled master is charged a turn so it drops to lowest priority.
          gnt_d        = GntNone;
          state_d      = StIdle;
          last_owner_d = owner_q;
        end
      end
      StBusy: begin
        if (bus_idle) begin
          gnt_d   = GntNone;
          state_d = StIdle;
        end else if (!owner_req || others_req) begin
          gnt_d = GntNone;
        end
      end
      default: begin
        gnt_d   = GntNone;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= GntNone;
      owner_q      <= '0;
      last_owner_q <= LastIdx;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign state = state_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: expected grantees queued at stimulus, popped on grant.
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic [1:0] state;
  logic       bus_idle;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit multi_seen = 1'b0;

  always #5 clk = ~clk;

  pci_arbiter #(
    .N_REQ      (4),
    .GNT_TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .frame   (frame),
    .irdy    (irdy),
    .gnt     (gnt),
    .owner   (owner),
    .state   (state),
    .bus_idle(bus_idle)
  );

  always @(negedge clk) begin
    if (!$isunknown(gnt) && !$onehot0(~gnt)) multi_seen = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advances until some gnt bit is low or the budget runs out; no comparison here.
  task automatic wait_gnt(input int budget, output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < budget && !ok; c++) begin
      cyc();
      for (int i = 0; i < 4; i++) begin
        if (gnt[i] === 1'b0) begin
          idx = i;
          ok  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; frame = 1'b1; irdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (gnt !== 4'b1111) begin
        errors++; $display("FAIL reset_gnt%0d: got %b want 1111", k, gnt);
      end
      checks++;
      if (state !== 2'd0) begin
        errors++; $display("FAIL reset_state%0d: got %0d want 0", k, state);
      end
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (gnt !== 4'b1110 || state !== 2'd1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: got gnt=%b st=%0d own=%0d want 1110/1/0", gnt, state, owner);
    end
    req = 4'b1111;
    cyc();
    checks++;
    if (gnt !== 4'b1111 || state !== 2'd0) begin
      errors++; $display("FAIL req_withdrawn: got gnt=%b st=%0d want 1111/0", gnt, state);
    end
  endtask

  task automatic test_rotation();
    int idx, exp;
    bit ok;
    req = 4'b0000;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_gnt(6, idx, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++; $display("FAIL rot_grant%0d: got gnt=%b want a queued grant", k, gnt);
      end else begin
        exp = exp_q.pop_front();
        if (gnt !== ~(4'b0001 << exp)) begin
          errors++; $display("FAIL rot_grant%0d: got gnt=%b want master %0d", k, gnt, exp);
        end
      end
      cyc();
      frame = 1'b0; irdy = 1'b0;
      repeat (3) cyc();
      frame = 1'b1; irdy = 1'b1;
      if (k == 4) req = 4'b1111;
      cyc();
      checks++;
      if (gnt !== 4'b1111 || state !== 2'd0) begin
        errors++; $display("FAIL rot_turnaround%0d: got gnt=%b st=%0d want 1111/0", k, gnt, state);
      end
    end
    cyc();
    checks++;
    if (gnt !== 4'b1111) begin
      errors++; $display("FAIL rot_parked: got %b want 1111", gnt);
    end
  endtask

  task automatic test_timeout();
    int idx, exp, low_cnt;
    bit ok;
    req = 4'b1011;
    exp_q.push_back(2);
    wait_gnt(6, idx, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL to_grant: got gnt=%b want a queued grant", gnt);
    end else begin
      exp = exp_q.pop_front();
      if (gnt !== ~(4'b0001 << exp)) begin
        errors++; $display("FAIL to_grant: got gnt=%b want master %0d", gnt, exp);
      end
    end
    low_cnt = (gnt[2] === 1'b0) ? 1 : 0;
    while (gnt[2] === 1'b0 && low_cnt < 40) begin
      cyc();
      if (gnt[2] === 1'b0) low_cnt++;
    end
    checks++;
    if (low_cnt != 16) begin
      errors++; $display("FAIL to_length: got %0d cycles want 16", low_cnt);
    end
    checks++;
    if (gnt !== 4'b1111 || state !== 2'd0) begin
      errors++; $display("FAIL to_revoke: got gnt=%b st=%0d want 1111/0", gnt, state);
    end
    req = 4'b1001;
    exp_q.push_back(1);
    wait_gnt(4, idx, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL to_next: got gnt=%b want a queued grant", gnt);
    end else begin
      exp = exp_q.pop_front();
      if (gnt !== ~(4'b0001 << exp)) begin
        errors++; $display("FAIL to_next: got gnt=%b want master %0d", gnt, exp);
      end
    end
    req = 4'b1111;
    cyc();
    checks++;
    if (gnt !== 4'b1111) begin
      errors++; $display("FAIL to_release: got %b want 1111", gnt);
    end
  endtask

  task automatic test_preempt();
    int idx, exp;
    bit ok;
    req = 4'b1110;
    exp_q.push_back(0);
    wait_gnt(4, idx, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || gnt !== ~(4'b0001 << exp_q[0])) begin
      errors++; $display("FAIL pre_grant: got gnt=%b want master 0", gnt);
    end
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    frame = 1'b0; irdy = 1'b0;
    cyc();
    checks++;
    if (state !== 2'd2 || gnt !== 4'b1110) begin
      errors++; $display("FAIL pre_busy: got gnt=%b st=%0d want 1110/2", gnt, state);
    end
    cyc();
    checks++;
    if (gnt !== 4'b1110) begin
      errors++; $display("FAIL pre_hold: got %b want 1110", gnt);
    end
    req = 4'b0110;
    exp_q.push_back(3);
    cyc();
    checks++;
    if (gnt !== 4'b1111 || state !== 2'd2) begin
      errors++; $display("FAIL pre_revoke: got gnt=%b st=%0d want 1111/2", gnt, state);
    end
    cyc();
    checks++;
    if (gnt !== 4'b1111) begin
      errors++; $display("FAIL pre_stay_off: got %b want 1111", gnt);
    end
    frame = 1'b1; irdy = 1'b1;
    cyc();
    checks++;
    if (gnt !== 4'b1111 || state !== 2'd0) begin
      errors++; $display("FAIL pre_idle: got gnt=%b st=%0d want 1111/0", gnt, state);
    end
    cyc();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL pre_next: got gnt=%b with empty queue", gnt);
    end else begin
      exp = exp_q.pop_front();
      if (gnt !== ~(4'b0001 << exp)) begin
        errors++; $display("FAIL pre_next: got gnt=%b want master %0d", gnt, exp);
      end
    end
    req = 4'b1111;
    cyc();
  endtask

  task automatic test_not_idle();
    int exp;
    frame = 1'b0; irdy = 1'b1; req = 4'b1101;
    #1;
    checks++;
    if (bus_idle !== 1'b0) begin
      errors++; $display("FAIL ni_bus_idle_lo: got %b want 0", bus_idle);
    end
    exp_q.push_back(1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (gnt !== 4'b1111 || state !== 2'd0) begin
        errors++; $display("FAIL ni_hold%0d: got gnt=%b st=%0d want 1111/0", k, gnt, state);
      end
    end
    frame = 1'b1;
    #1;
    checks++;
    if (bus_idle !== 1'b1 || gnt !== 4'b1111) begin
      errors++; $display("FAIL ni_bus_idle_hi: got idle=%b gnt=%b want 1/1111", bus_idle, gnt);
    end
    cyc();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL ni_grant: got gnt=%b with empty queue", gnt);
    end else begin
      exp = exp_q.pop_front();
      if (gnt !== ~(4'b0001 << exp)) begin
        errors++; $display("FAIL ni_grant: got gnt=%b want master %0d", gnt, exp);
      end
    end
  endtask

  task automatic test_busy_reset();
    int exp;
    frame = 1'b0; irdy = 1'b0;
    cyc();
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL br_busy: got st=%0d want 2", state);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (gnt !== 4'b1111 || state !== 2'd0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL br_reset: got gnt=%b st=%0d own=%0d want 1111/0/0", gnt, state, owner);
    end
    rst = 1'b0; frame = 1'b1; irdy = 1'b1;
    exp_q.push_back(1);
    cyc();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL br_resume: got gnt=%b with empty queue", gnt);
    end else begin
      exp = exp_q.pop_front();
      if (gnt !== ~(4'b0001 << exp)) begin
        errors++; $display("FAIL br_resume: got gnt=%b want master %0d", gnt, exp);
      end
    end
    req = 4'b1111;
    cyc();
  endtask

  task automatic test_drop_ignored();
    req = 4'b1110;
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (gnt !== 4'b1111) begin
        errors++; $display("FAIL drop_%0d: got %b want 1111", k, gnt);
      end
    end
  endtask

  task automatic test_onehot();
    checks++;
    if (multi_seen !== 1'b0) begin
      errors++; $display("FAIL onehot: got multiple grants seen=%b want 0", multi_seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; frame = 1'b1; irdy = 1'b1;
    test_reset();
    test_rotation();
    test_timeout();
    test_preempt();
    test_not_idle();
    test_busy_reset();
    test_drop_ignored();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
